// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op codes, vector selects,
// vector base and FSM state encoding.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_NOP     = 3'd0,
    PC_INC     = 3'd1,
    PC_LOAD_LO = 3'd2,
    PC_LOAD_HI = 3'd3,
    PC_BRANCH  = 3'd4,
    PC_VECTOR  = 3'd5
  } pc_op_t;

  localparam logic [1:0] VEC_NMI   = 2'd0;
  localparam logic [1:0] VEC_RESET = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;
  localparam logic [1:0] VEC_RSVD  = 2'd3;

  localparam logic [7:0] VEC_BASE = 8'hFA;

  typedef logic [0:0] pc_state_t;
  localparam pc_state_t ST_IDLE   = 1'b0;
  localparam pc_state_t ST_BR_FIX = 1'b1;

  // Low byte of the vector address: NMI=FA, RESET=FC, IRQ/BRK=FE.
  function automatic logic [7:0] vec_lo(input logic [1:0] sel);
    return VEC_BASE + {5'd0, sel, 1'b0};
  endfunction

endpackage

// File: rtl/pc_branch_adder.sv
// Signed 8-bit relative add on PCL, reporting whether the target left the page
// and in which direction PCH must be adjusted.
module pc_branch_adder (
  input  logic [7:0] i_pcl,
  input  logic [7:0] i_off,
  output logic [7:0] o_pcl,
  output logic       o_cross,
  output logic       o_dir
);

  logic [8:0] w_sum;

  assign w_sum = {1'b0, i_pcl} + {1'b0, i_off};
  assign o_pcl = w_sum[7:0];
  // A negative offset is a two's-complement add, so a missing carry means a borrow.
  assign o_cross = i_off[7] ? ~w_sum[8] : w_sum[8];
  assign o_dir   = ~i_off[7];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: full-width PC with increment, two-step load, relative
// branch with page-cross fix-up cycle, and hardware vector entry.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {{(ADDR_W-8){1'b1}}, 8'hFC},
  localparam int               NB       = ADDR_W / 8,
  localparam int               SEL_W    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              fclk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        pc_op,
  input  logic [1:0]        vec_sel,
  input  logic [7:0]        db_in,
  input  logic [SEL_W-1:0]  db_sel,
  output logic [7:0]        db_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              page_cross,
  output logic              carry_done,
  output pc_state_t         dbg_state
);

  localparam int                HI_W   = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [HI_W-1:0]   HI_ONE = {{(HI_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_lo_tmp;
  pc_state_t         r_state;
  logic              r_dir;
  logic              r_page_cross;
  logic              r_carry_done;

  pc_op_t            w_op;
  logic [7:0]        w_br_pcl;
  logic              w_br_cross;
  logic              w_br_dir;
  logic [HI_W-1:0]   w_ld_hi;
  logic [HI_W-1:0]   w_pch_fix;
  logic [7:0]        w_db_out;

  assign w_op = pc_op_t'(pc_op);

  pc_branch_adder u_branch_adder (
    .i_pcl   (r_pc[7:0]),
    .i_off   (db_in),
    .o_pcl   (w_br_pcl),
    .o_cross (w_br_cross),
    .o_dir   (w_br_dir)
  );

  always_comb begin
    w_ld_hi      = '0;
    w_ld_hi[7:0] = db_in;
  end

  assign w_pch_fix = r_dir ? (r_pc[ADDR_W-1:8] + HI_ONE)
                           : (r_pc[ADDR_W-1:8] - HI_ONE);

  // Handshake: an op is taken on a rising edge when op_valid=1 and busy=0;
  // while busy=1 the op is dropped, so the sequencer must hold off itself.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_lo_tmp     <= 8'h00;
      r_state      <= ST_IDLE;
      r_dir        <= 1'b0;
      r_page_cross <= 1'b0;
      r_carry_done <= 1'b0;
    end else begin
      r_page_cross <= 1'b0;
      r_carry_done <= 1'b0;
      case (r_state)
        ST_BR_FIX: begin
          r_pc[ADDR_W-1:8] <= w_pch_fix;
          r_state          <= ST_IDLE;
        end
        default: begin
          if (op_valid) begin
            case (w_op)
              PC_INC: begin
                r_pc         <= r_pc + PC_ONE;
                r_carry_done <= (r_pc[7:0] == 8'hFF);
              end
              PC_LOAD_LO: r_lo_tmp <= db_in;
              PC_LOAD_HI: r_pc <= {w_ld_hi, r_lo_tmp};
              PC_BRANCH: begin
                r_pc[7:0] <= w_br_pcl;
                if (w_br_cross) begin
                  r_dir        <= w_br_dir;
                  r_state      <= ST_BR_FIX;
                  r_page_cross <= 1'b1;
                end
              end
              PC_VECTOR: begin
                if (vec_sel != VEC_RSVD) begin
                  r_pc <= {{HI_W{1'b1}}, vec_lo(vec_sel)};
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Out-of-range byte selects read as zero.
  always_comb begin
    w_db_out = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (db_sel == SEL_W'(i)) begin
        w_db_out = r_pc[i*8 +: 8];
      end
    end
  end

  assign db_out     = w_db_out;
  assign addr_out   = r_pc;
  assign busy       = (r_state == ST_BR_FIX);
  assign page_cross = r_page_cross;
  assign carry_done = r_carry_done;
  assign dbg_state  = r_state;

endmodule
